instr_prefetch_buf: RTL and testbench

Fetch stage sitting upstream of the decode/register-file stage of the NIOS II core. It replaces the direct PC-to-instruction-ROM path with a small prefetch queue in front of an instruction memory that may take several cycles per access. The block generates sequential fetch addresses and holds up to DEPTH fetched instructions, each tagged with its PC. It discards in-flight or queued instructions when the branch unit redirects the PC.

---
 rtl/instr_prefetch_buf_pkg.sv | 18 +
 rtl/instr_prefetch_buf_if.sv | 26 ++
 rtl/instr_prefetch_buf_sync_fifo.sv | 78 +++++++
 rtl/instr_prefetch_buf.sv | 112 +++++++++++
 tb/tb_instr_prefetch_buf.sv | 346 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_prefetch_buf_pkg.sv
// Shared types and constants for the instruction prefetch buffer.
package instr_prefetch_buf_pkg;

    localparam int WORD_W = 32;
    localparam logic [WORD_W-1:0] PC_INC = 32'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [WORD_W-1:0] instr;
        logic [WORD_W-1:0] pc;
    } entry_t;

endpackage

// File: rtl/instr_prefetch_buf_if.sv
// Memory-side and consumer-side signals of the prefetch buffer.
interface instr_prefetch_buf_if;
    import instr_prefetch_buf_pkg::*;

    logic              imem_req;
    logic [WORD_W-1:0] imem_addr;
    logic              imem_ack;
    logic [WORD_W-1:0] imem_rdata;
    logic              inst_valid;
    logic [WORD_W-1:0] inst_out;
    logic [WORD_W-1:0] inst_pc;
    logic              inst_ready;
    logic              redirect;
    logic [WORD_W-1:0] redirect_pc;

    modport master (
        output imem_req, imem_addr, inst_valid, inst_out, inst_pc,
        input  imem_ack, imem_rdata, inst_ready, redirect, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, inst_valid, inst_out, inst_pc,
        output imem_ack, imem_rdata, inst_ready, redirect, redirect_pc
    );

endinterface

// File: rtl/instr_prefetch_buf_sync_fifo.sv
// DEPTH-entry queue of {instr, pc} with push/pop/flush and an occupancy count.
module instr_prefetch_buf_sync_fifo
    import instr_prefetch_buf_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       srst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  entry_t                     wr_data,
    output entry_t                     rd_data,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    entry_t             mem_reg [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [CNT_W-1:0]   count_reg;
    logic [DEPTH-1:0]   wr_en;
    logic               do_push;
    logic               do_pop;

    // Flush wins over any same-edge push or pop; pop on empty is a no-op.
    assign do_push = push && !flush && (count_reg != FULL_CNT);
    assign do_pop  = pop && !flush && (count_reg != '0);

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_wr_en
            assign wr_en[gi] = do_push && (wr_ptr_reg == PTR_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (srst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_en[i]) begin
                    mem_reg[i] <= wr_data;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (srst || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Head is read straight from the array so a push into an empty queue is visible next cycle.
    assign rd_data = mem_reg[rd_ptr_reg];
    assign count   = count_reg;

endmodule

// File: rtl/instr_prefetch_buf.sv
// Sequential instruction fetcher with a small tagged prefetch queue and redirect flush.
module instr_prefetch_buf
    import instr_prefetch_buf_pkg::*;
#(
    parameter int                DEPTH    = 4,
    parameter logic [WORD_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                  clock,
    input  logic                  reset,
    instr_prefetch_buf_if.master  bus
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    fetch_state_t       state_reg;
    logic [WORD_W-1:0]  fetch_pc_reg;
    logic [WORD_W-1:0]  imem_addr_reg;
    logic               imem_req_reg;

    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   count_next;
    entry_t             head;
    entry_t             wr_entry;
    logic               push;
    logic               pop;
    logic               room_next;
    logic [WORD_W-1:0]  pc_plus;
    logic [WORD_W-1:0]  redirect_word;

    assign pop           = bus.inst_ready && (count != '0);
    assign push          = (state_reg == ST_WAIT) && imem_req_reg && bus.imem_ack && !bus.redirect;
    assign count_next    = count + CNT_W'(push) - CNT_W'(pop);
    assign room_next     = (count_next < FULL_CNT);
    assign pc_plus       = fetch_pc_reg + PC_INC;
    assign redirect_word = bus.redirect_pc & ~WORD_W'(3);
    assign wr_entry      = '{instr: bus.imem_rdata, pc: imem_addr_reg};

    instr_prefetch_buf_sync_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clock),
        .srst    (reset),
        .push    (push),
        .pop     (pop),
        .flush   (bus.redirect),
        .wr_data (wr_entry),
        .rd_data (head),
        .count   (count)
    );

    // fetch_pc always equals imem_addr while a wanted request is outstanding.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            fetch_pc_reg  <= RESET_PC;
            imem_req_reg  <= 1'b0;
            imem_addr_reg <= '0;
        end else if (bus.redirect) begin
            fetch_pc_reg <= redirect_word;
            case (state_reg)
                ST_WAIT, ST_DROP: begin
                    if (bus.imem_ack) begin
                        state_reg    <= ST_IDLE;
                        imem_req_reg <= 1'b0;
                    end else begin
                        state_reg <= ST_DROP;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (room_next) begin
                        state_reg     <= ST_WAIT;
                        imem_req_reg  <= 1'b1;
                        imem_addr_reg <= fetch_pc_reg;
                    end
                end
                ST_WAIT: begin
                    if (bus.imem_ack) begin
                        fetch_pc_reg <= pc_plus;
                        if (room_next) begin
                            imem_addr_reg <= pc_plus;
                        end else begin
                            state_reg    <= ST_IDLE;
                            imem_req_reg <= 1'b0;
                        end
                    end
                end
                ST_DROP: begin
                    if (bus.imem_ack) begin
                        state_reg    <= ST_IDLE;
                        imem_req_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg    <= ST_IDLE;
                    imem_req_reg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.imem_req   = imem_req_reg;
    assign bus.imem_addr  = imem_addr_reg;
    assign bus.inst_valid = (count != '0);
    assign bus.inst_out   = head.instr;
    assign bus.inst_pc    = head.pc;

endmodule

// File: tb/tb_instr_prefetch_buf.sv
// Bench for instr_prefetch_buf: vector table, directed corner cases, random run against a queue model.
module tb_instr_prefetch_buf;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    typedef struct {
        logic        redir;
        logic [31:0] rpc;
        logic        ready;
        logic        ack;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    logic clock;
    logic reset;

    instr_prefetch_buf_if bus ();

    instr_prefetch_buf #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int          errors = 0;
    int          checks = 0;

    // stimulus drivers, applied by cycle()
    logic        reset_drv;
    logic        redir_drv;
    logic [31:0] rpc_drv;
    logic        ready_drv;
    logic        ack_manual_mode;
    logic        ack_manual;
    logic        lat_rand;
    logic        spurious_en;
    int          lat_fixed;
    int          mem_lat;
    int          mem_wait;

    // reference model state
    ent_t        q[$];
    logic [31:0] pop_log[$];
    logic [31:0] exp_fetch;
    logic        stale;
    logic        watch_en;
    logic [31:0] watch_pc;
    logic        seen_stale;

    vec_t        vecs[8];

    function automatic logic [31:0] mem_word(logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Transaction-level model: delivered stream is sequential from the last redirect target.
    task automatic model_step(logic ack);
        if (reset_drv) begin
            q.delete();
            exp_fetch = RESET_PC;
            stale     = 1'b0;
            return;
        end
        if (redir_drv) begin
            q.delete();
            exp_fetch = rpc_drv & 32'hFFFF_FFFC;
            stale     = (bus.imem_req === 1'b1) && !ack;
            return;
        end
        if (ready_drv && q.size() != 0) begin
            pop_log.push_back(q[0].pc);
            void'(q.pop_front());
        end
        if (bus.imem_req === 1'b1 && ack) begin
            if (stale) begin
                stale = 1'b0;
            end else begin
                chk("fetch_addr", bus.imem_addr, exp_fetch);
                q.push_back('{instr: mem_word(bus.imem_addr), pc: bus.imem_addr});
                exp_fetch = exp_fetch + 32'd4;
                chk("no_overflow", 32'(q.size() <= DEPTH), 32'd1);
            end
        end
    endtask

    task automatic model_check(logic hold, logic [31:0] pre_addr);
        chk("valid", 32'(bus.inst_valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            chk("head_pc", bus.inst_pc, q[0].pc);
            chk("head_instr", bus.inst_out, q[0].instr);
        end
        if (hold) begin
            chk("req_hold", 32'(bus.imem_req), 32'd1);
            chk("addr_hold", bus.imem_addr, pre_addr);
        end
        if (watch_en && bus.inst_valid === 1'b1 && bus.inst_pc == watch_pc) begin
            seen_stale = 1'b1;
        end
    endtask

    // One clock: drive inputs, advance model, take the edge, check at the falling edge.
    task automatic cycle();
        logic        ack;
        logic        hold;
        logic [31:0] pre_addr;
        if (ack_manual_mode) begin
            ack = ack_manual;
        end else if (bus.imem_req === 1'b1) begin
            if (mem_wait >= mem_lat) begin
                ack      = 1'b1;
                mem_wait = 0;
                mem_lat  = lat_rand ? int'($urandom_range(0, 3)) : lat_fixed;
            end else begin
                ack      = 1'b0;
                mem_wait = mem_wait + 1;
            end
        end else begin
            ack = spurious_en && ($urandom_range(0, 3) == 0);
        end
        if (reset_drv) begin
            mem_wait = 0;
        end
        bus.imem_ack    = ack;
        bus.imem_rdata  = ack ? mem_word(bus.imem_addr) : $urandom();
        bus.inst_ready  = ready_drv;
        bus.redirect    = redir_drv;
        bus.redirect_pc = rpc_drv;
        reset           = reset_drv;
        hold     = (bus.imem_req === 1'b1) && !ack && !reset_drv;
        pre_addr = bus.imem_addr;
        model_step(ack);
        @(posedge clock);
        @(negedge clock);
        model_check(hold, pre_addr);
    endtask

    task automatic set_latency(int lat);
        ack_manual_mode = 1'b0;
        lat_rand        = 1'b0;
        lat_fixed       = lat;
        mem_lat         = lat;
        mem_wait        = 0;
    endtask

    task automatic do_reset();
        reset_drv  = 1'b1;
        redir_drv  = 1'b0;
        ready_drv  = 1'b0;
        ack_manual = 1'b0;
        cycle();
        chk("rst_valid", 32'(bus.inst_valid), 32'd0);
        chk("rst_req", 32'(bus.imem_req), 32'd0);
        chk("rst_inst_out", bus.inst_out, 32'd0);
        chk("rst_inst_pc", bus.inst_pc, 32'd0);
        chk("rst_addr", bus.imem_addr, 32'd0);
        reset_drv = 1'b0;
    endtask

    task automatic redirect_to(logic [31:0] pc);
        redir_drv = 1'b1;
        rpc_drv   = pc;
        cycle();
        redir_drv = 1'b0;
    endtask

    task automatic run_until_addr(logic [31:0] addr, string name);
        logic found = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (bus.imem_req === 1'b1 && bus.imem_addr == addr) begin
                found = 1'b1;
                break;
            end
            cycle();
        end
        chk(name, 32'(found), 32'd1);
    endtask

    initial begin
        reset_drv = 1'b1; redir_drv = 1'b0; rpc_drv = '0; ready_drv = 1'b0;
        ack_manual_mode = 1'b1; ack_manual = 1'b0; lat_rand = 1'b0; spurious_en = 1'b0;
        lat_fixed = 0; mem_lat = 0; mem_wait = 0;
        exp_fetch = RESET_PC; stale = 1'b0;
        watch_en = 1'b0; watch_pc = '0; seen_stale = 1'b0;
        reset = 1'b1;
        bus.imem_ack = 1'b0; bus.imem_rdata = '0; bus.inst_ready = 1'b0;
        bus.redirect = 1'b0; bus.redirect_pc = '0;
        @(negedge clock);

        // Zero-wait streaming, then a redirect coinciding with an ack.
        vecs[0] = '{1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 32'h0,   1'b0, 32'h0};
        vecs[1] = '{1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 32'h4,   1'b1, 32'h0};
        vecs[2] = '{1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 32'h8,   1'b1, 32'h4};
        vecs[3] = '{1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 32'hC,   1'b1, 32'h8};
        vecs[4] = '{1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 32'h10,  1'b1, 32'hC};
        vecs[5] = '{1'b1, 32'h203, 1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0};
        vecs[6] = '{1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 32'h200, 1'b0, 32'h0};
        vecs[7] = '{1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 32'h204, 1'b1, 32'h200};

        do_reset();
        ack_manual_mode = 1'b1;
        for (int i = 0; i < 8; i++) begin
            redir_drv  = vecs[i].redir;
            rpc_drv    = vecs[i].rpc;
            ready_drv  = vecs[i].ready;
            ack_manual = vecs[i].ack;
            cycle();
            chk($sformatf("tv%0d_req", i), 32'(bus.imem_req), 32'(vecs[i].exp_req));
            if (vecs[i].exp_req) chk($sformatf("tv%0d_addr", i), bus.imem_addr, vecs[i].exp_addr);
            chk($sformatf("tv%0d_valid", i), 32'(bus.inst_valid), 32'(vecs[i].exp_valid));
            if (vecs[i].exp_valid) begin
                chk($sformatf("tv%0d_pc", i), bus.inst_pc, vecs[i].exp_pc);
                chk($sformatf("tv%0d_out", i), bus.inst_out, mem_word(vecs[i].exp_pc));
            end
        end
        redir_drv = 1'b0;

        // Consumer stalled, 2-cycle memory: queue fills to DEPTH and fetching stops.
        do_reset();
        set_latency(1);
        for (int i = 0; i < 30; i++) cycle();
        chk("full_req", 32'(bus.imem_req), 32'd0);
        chk("full_count", 32'(q.size()), 32'd4);
        chk("full_head", bus.inst_pc, 32'h0);
        pop_log.delete();
        ready_drv = 1'b1;
        cycle();
        chk("refill_req", 32'(bus.imem_req), 32'd1);
        chk("refill_addr", bus.imem_addr, 32'h10);
        for (int i = 0; i < 20; i++) cycle();
        chk("drain_n", 32'(pop_log.size() >= 6), 32'd1);
        for (int i = 0; i < 6 && i < pop_log.size(); i++) begin
            chk($sformatf("drain_pc%0d", i), pop_log[i], 32'(i * 4));
        end

        // Redirect with a full queue and no request outstanding.
        do_reset();
        set_latency(0);
        for (int i = 0; i < 12; i++) cycle();
        redirect_to(32'h43);
        chk("rdi_valid", 32'(bus.inst_valid), 32'd0);
        chk("rdi_req", 32'(bus.imem_req), 32'd0);
        cycle();
        chk("rdi_addr", bus.imem_addr, 32'h40);
        ready_drv = 1'b1;
        for (int i = 0; i < 10 && bus.inst_valid !== 1'b1; i++) cycle();
        chk("rdi_first_pc", bus.inst_pc, 32'h40);

        // Redirect while a request is outstanding: its data must be dropped.
        do_reset();
        ack_manual_mode = 1'b1;
        redirect_to(32'h10);
        cycle();
        chk("drop_issue", bus.imem_addr, 32'h10);
        watch_en = 1'b1; watch_pc = 32'h10; seen_stale = 1'b0;
        redirect_to(32'h80);
        chk("drop_req", 32'(bus.imem_req), 32'd1);
        chk("drop_addr", bus.imem_addr, 32'h10);
        cycle();
        cycle();
        ack_manual = 1'b1;
        cycle();
        chk("drop_done", 32'(bus.imem_req), 32'd0);
        ack_manual = 1'b0;
        cycle();
        chk("drop_next", bus.imem_addr, 32'h80);
        ack_manual = 1'b1;
        ready_drv  = 1'b1;
        cycle();
        chk("drop_pc", bus.inst_pc, 32'h80);
        for (int i = 0; i < 4; i++) cycle();
        chk("drop_stale", 32'(seen_stale), 32'd0);
        watch_en = 1'b0;

        // Redirect on the same edge as an ack and a pop.
        do_reset();
        ack_manual_mode = 1'b1;
        redirect_to(32'h18);
        ack_manual = 1'b1;
        run_until_addr(32'h20, "ack_rd_setup");
        ready_drv = 1'b1;
        redirect_to(32'h300);
        chk("ack_rd_valid", 32'(bus.inst_valid), 32'd0);
        chk("ack_rd_req", 32'(bus.imem_req), 32'd0);
        ack_manual = 1'b0;
        cycle();
        chk("ack_rd_addr", bus.imem_addr, 32'h300);
        ack_manual = 1'b1;
        cycle();
        chk("ack_rd_pc", bus.inst_pc, 32'h300);

        // Reset during WAIT with two entries queued.
        do_reset();
        ack_manual_mode = 1'b1;
        ack_manual = 1'b1;
        run_until_addr(32'h8, "rst_wait_setup");
        ack_manual = 1'b0;
        cycle();
        chk("rst_wait_q", 32'(q.size()), 32'd2);
        do_reset();
        cycle();
        chk("rst_restart", bus.imem_addr, RESET_PC);

        // Random traffic, including redirects near the top of the address space.
        do_reset();
        ack_manual_mode = 1'b0;
        lat_rand        = 1'b1;
        spurious_en     = 1'b1;
        mem_lat         = 0;
        pop_log.delete();
        for (int i = 0; i < 3000; i++) begin
            ready_drv = ($urandom_range(0, 9) < 7);
            redir_drv = ($urandom_range(0, 29) == 0);
            rpc_drv   = ($urandom_range(0, 2) == 0) ? (32'hFFFF_FFE0 | 32'($urandom_range(0, 31)))
                                                     : $urandom();
            cycle();
        end
        chk("progress", 32'(pop_log.size() > 300), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
